// File: rtl/sync_fifo_v.sv
// sync_fifo_v
// Single-clock FIFO with a registered read port and a per-word valid strobe.
// Provides full/empty flags, programmable almost_full/almost_empty thresholds
// and an occupancy count. All flags decode the registered occupancy counter,
// so they are stable right after each clock edge.

module sync_fifo_v #(
    parameter int DEEPWID = 3,
    parameter int DEEP    = 8,
    parameter int BITWID  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [BITWID-1:0]    wr_dat,
    output logic [BITWID-1:0]    rd_dat,
    output logic                 rd_dat_vld,
    input  logic [DEEPWID-1:0]   cfg_almost_full,
    input  logic [DEEPWID-1:0]   cfg_almost_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 full,
    output logic                 empty,
    output logic [DEEPWID:0]     fifo_num
);

    localparam logic [DEEPWID-1:0] PTR_ONE   = DEEPWID'(1);
    localparam logic [DEEPWID:0]   CNT_ONE   = (DEEPWID + 1)'(1);
    localparam logic [DEEPWID:0]   DEPTH_CNT = (DEEPWID + 1)'(DEEP);

    logic [BITWID-1:0]  my_memory [DEEP];
    logic [DEEPWID-1:0] wr_ptr;
    logic [DEEPWID-1:0] rd_ptr;
    logic               wr_acc;
    logic               rd_acc;

    // Acceptance is judged against the flags as they stand before the edge,
    // so a full FIFO only reads and an empty FIFO only writes.
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    // Flags are pure decodes of the registered occupancy count.
    assign full         = (fifo_num == DEPTH_CNT);
    assign empty        = (fifo_num == '0);
    assign almost_full  = (fifo_num >= {1'b0, cfg_almost_full});
    assign almost_empty = (fifo_num <= {1'b0, cfg_almost_empty});

    // Storage is deliberately not reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            my_memory[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEEP; the counter tracks net writes minus reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_num <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fifo_num <= fifo_num + CNT_ONE;
                2'b01:   fifo_num <= fifo_num - CNT_ONE;
                default: fifo_num <= fifo_num;
            endcase
        end
    end

    // Registered read port: data holds between reads, valid pulses one cycle per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat     <= '0;
            rd_dat_vld <= 1'b0;
        end else begin
            rd_dat_vld <= rd_acc;
            if (rd_acc) begin
                rd_dat <= my_memory[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_v.sv
// tb_sync_fifo_v
// Directed checks of reset, fill/drain, overflow/underflow, simultaneous
// access, thresholds and asynchronous reset, followed by a flag-gated random
// soak compared against a queue model.

module tb_sync_fifo_v;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [4:0] wr_dat;
    logic [4:0] rd_dat;
    logic       rd_dat_vld;
    logic [2:0] cfg_almost_full;
    logic [2:0] cfg_almost_empty;
    logic       almost_full;
    logic       almost_empty;
    logic       full;
    logic       empty;
    logic [3:0] fifo_num;

    int assert_count;
    int fail_count;

    logic [4:0] model_q[$];
    logic [4:0] pend_dat;
    logic [4:0] rnd_dat;
    logic       exp_vld;
    logic       do_wr;
    logic       do_rd;
    int         pre_size;

    sync_fifo_v #(
        .DEEPWID(3),
        .DEEP(8),
        .BITWID(5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr               (wr),
        .rd               (rd),
        .wr_dat           (wr_dat),
        .rd_dat           (rd_dat),
        .rd_dat_vld       (rd_dat_vld),
        .cfg_almost_full  (cfg_almost_full),
        .cfg_almost_empty (cfg_almost_empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .full             (full),
        .empty            (empty),
        .fifo_num         (fifo_num)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of requests, then sample 1 unit after the rising edge.
    task automatic applyStimulus(input logic wr_i, input logic rd_i, input logic [4:0] dat_i);
        wr     = wr_i;
        rd     = rd_i;
        wr_dat = dat_i;
        @(posedge clk);
        #1;
        wr     = 1'b0;
        rd     = 1'b0;
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        assert_count     = 0;
        fail_count       = 0;
        rst              = 1'b1;
        wr               = 1'b0;
        rd               = 1'b0;
        wr_dat           = '0;
        cfg_almost_full  = 3'd6;
        cfg_almost_empty = 3'd2;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_num", 32'(fifo_num), 32'd0);
        checkOutput("rst_vld", 32'(rd_dat_vld), 32'd0);
        checkOutput("rst_rddat", 32'(rd_dat), 32'd0);
        checkOutput("rst_aempty", 32'(almost_empty), 32'd1);
        checkOutput("rst_afull", 32'(almost_full), 32'd0);
        rst = 1'b0;

        // Fill with 1..8, watching thresholds along the way
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i));
            checkOutput("fill_num", 32'(fifo_num), 32'(i));
            checkOutput("fill_aempty", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            checkOutput("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            checkOutput("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
        end

        // Overflow write is dropped
        applyStimulus(1'b1, 1'b0, 5'd31);
        checkOutput("ovf_num", 32'(fifo_num), 32'd8);
        checkOutput("ovf_full", 32'(full), 32'd1);

        // Read back 1..8 in order, valid one cycle after each read
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd0);
            checkOutput("drain_vld", 32'(rd_dat_vld), 32'd1);
            checkOutput("drain_dat", 32'(rd_dat), 32'(i));
            checkOutput("drain_num", 32'(fifo_num), 32'(8 - i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkOutput("idle_vld", 32'(rd_dat_vld), 32'd0);

        // Underflow read: nothing happens, rd_dat holds the last word
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkOutput("udf_vld", 32'(rd_dat_vld), 32'd0);
        checkOutput("udf_num", 32'(fifo_num), 32'd0);
        checkOutput("udf_dat", 32'(rd_dat), 32'd8);

        // Simultaneous access with 3 words stored
        applyStimulus(1'b1, 1'b0, 5'd10);
        applyStimulus(1'b1, 1'b0, 5'd11);
        applyStimulus(1'b1, 1'b0, 5'd12);
        applyStimulus(1'b1, 1'b1, 5'd13);
        checkOutput("rw3_num", 32'(fifo_num), 32'd3);
        checkOutput("rw3_vld", 32'(rd_dat_vld), 32'd1);
        checkOutput("rw3_dat", 32'(rd_dat), 32'd10);

        // Fill to full (11,12,13,14..18), then simultaneous access drops the write
        for (int i = 14; i <= 18; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i));
        end
        checkOutput("rwf_full_pre", 32'(full), 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd19);
        checkOutput("rwf_num", 32'(fifo_num), 32'd7);
        checkOutput("rwf_dat", 32'(rd_dat), 32'd11);
        for (int i = 12; i <= 18; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd0);
            checkOutput("rwf_drain_dat", 32'(rd_dat), 32'(i));
        end
        checkOutput("rwf_empty", 32'(empty), 32'd1);

        // Simultaneous access while empty: only the write happens
        applyStimulus(1'b1, 1'b1, 5'd21);
        checkOutput("rwe_num", 32'(fifo_num), 32'd1);
        checkOutput("rwe_vld", 32'(rd_dat_vld), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkOutput("rwe_dat", 32'(rd_dat), 32'd21);

        // Asynchronous reset mid-operation, checked before the next edge
        applyStimulus(1'b1, 1'b0, 5'd5);
        applyStimulus(1'b1, 1'b1, 5'd6);
        rst = 1'b1;
        #1;
        checkOutput("arst_num", 32'(fifo_num), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        checkOutput("arst_vld", 32'(rd_dat_vld), 32'd0);
        checkOutput("arst_dat", 32'(rd_dat), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random soak gated by flags sampled after the previous edge
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            do_wr   = ($urandom_range(0, 1) == 1) && !full;
            do_rd   = ($urandom_range(0, 1) == 1) && !empty;
            rnd_dat = 5'($urandom_range(0, 31));
            pre_size = model_q.size();
            exp_vld  = 1'b0;
            if (do_rd && pre_size > 0) begin
                pend_dat = model_q.pop_front();
                exp_vld  = 1'b1;
            end
            if (do_wr && pre_size < 8) begin
                model_q.push_back(rnd_dat);
            end
            applyStimulus(do_wr, do_rd, rnd_dat);
            checkOutput("soak_vld", 32'(rd_dat_vld), 32'(exp_vld));
            if (exp_vld) begin
                checkOutput("soak_dat", 32'(rd_dat), 32'(pend_dat));
            end
            checkOutput("soak_num", 32'(fifo_num), 32'(model_q.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
